// File: rtl/axi_lite_pkg.sv
// Shared definitions for the AXI4-Lite GPIO slave: response codes, register
// offsets, FSM state types and the byte-strobe expansion helper.
package axi_lite_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [4:0] ADDR_GPIO_OUT = 5'h00;
    localparam logic [4:0] ADDR_GPIO_IN  = 5'h04;
    localparam logic [4:0] ADDR_SCRATCH  = 5'h08;
    localparam logic [4:0] ADDR_ID       = 5'h0C;

    typedef enum logic {
        W_IDLE = 1'b0,
        W_RESP = 1'b1
    } wState_t;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } rState_t;

    function automatic logic [31:0] strbToMask(input logic [3:0] strb);
        logic [31:0] mask;
        for (int i = 0; i < 4; i++) begin
            mask[8*i +: 8] = {8{strb[i]}};
        end
        return mask;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser bringing asynchronous pins into the clk domain.
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [WIDTH-1:0] i_async,
    output logic [WIDTH-1:0] o_sync
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
        end
    end

    assign o_sync = r_sync;

endmodule

// File: rtl/axi_lite_gpio_slave.sv
// AXI4-Lite slave with GPIO output, synchronised GPIO input, scratch and ID
// registers. Write and read paths are independent FSMs.
module axi_lite_gpio_slave
    import axi_lite_pkg::*;
#(
    parameter int                GPIO_W   = 8,
    parameter logic [GPIO_W-1:0] GPIO_RST = '0,
    parameter logic [31:0]       ID_VALUE = 32'h4158_4C01
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [31:0]       S_AXI_AWADDR,
    input  logic              S_AXI_AWVALID,
    output logic              S_AXI_AWREADY,
    input  logic [31:0]       S_AXI_WDATA,
    input  logic [3:0]        S_AXI_WSTRB,
    input  logic              S_AXI_WVALID,
    output logic              S_AXI_WREADY,
    output logic [1:0]        S_AXI_BRESP,
    output logic              S_AXI_BVALID,
    input  logic              S_AXI_BREADY,
    input  logic [31:0]       S_AXI_ARADDR,
    input  logic              S_AXI_ARVALID,
    output logic              S_AXI_ARREADY,
    output logic [31:0]       S_AXI_RDATA,
    output logic [1:0]        S_AXI_RRESP,
    output logic              S_AXI_RVALID,
    input  logic              S_AXI_RREADY,
    output logic [GPIO_W-1:0] gpio_out,
    input  logic [GPIO_W-1:0] gpio_in
);

    wState_t           r_wState;
    wState_t           w_wStateNext;
    rState_t           r_rState;
    rState_t           w_rStateNext;
    logic              r_awHeld;
    logic              r_wHeld;
    logic [2:0]        r_awIdx;
    logic [31:0]       r_wData;
    logic [3:0]        r_wStrb;
    logic [1:0]        r_bResp;
    logic [31:0]       r_rData;
    logic [1:0]        r_rResp;
    logic [GPIO_W-1:0] r_gpioOut;
    logic [31:0]       r_scratch;
    logic [GPIO_W-1:0] w_gpioIn;
    logic              w_awHs;
    logic              w_wHs;
    logic              w_arHs;
    logic              w_commit;
    logic              w_wrOk;
    logic              w_rdOk;
    logic [4:0]        w_wrOffset;
    logic [4:0]        w_rdOffset;
    logic [31:0]       w_wrMask;
    logic [31:0]       w_gpioMerged;
    logic [31:0]       w_rdData;
    logic              w_unused;

    sync_2ff #(
        .WIDTH (GPIO_W)
    ) u_gpioSync (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_async (gpio_in),
        .o_sync  (w_gpioIn)
    );

    assign w_awHs   = S_AXI_AWVALID && S_AXI_AWREADY;
    assign w_wHs    = S_AXI_WVALID && S_AXI_WREADY;
    assign w_arHs   = S_AXI_ARVALID && S_AXI_ARREADY;
    assign w_commit = (r_wState == W_IDLE) && r_awHeld && r_wHeld;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wState <= W_IDLE;
        end else begin
            r_wState <= w_wStateNext;
        end
    end

    always_comb begin
        w_wStateNext = r_wState;
        case (r_wState)
            W_IDLE:  if (w_commit) w_wStateNext = W_RESP;
            W_RESP:  if (S_AXI_BREADY) w_wStateNext = W_IDLE;
            default: w_wStateNext = W_IDLE;
        endcase
    end

    always_comb begin
        S_AXI_AWREADY = 1'b0;
        S_AXI_WREADY  = 1'b0;
        S_AXI_BVALID  = 1'b0;
        case (r_wState)
            W_IDLE: begin
                S_AXI_AWREADY = !r_awHeld;
                S_AXI_WREADY  = !r_wHeld;
            end
            W_RESP:  S_AXI_BVALID = 1'b1;
            default: S_AXI_BVALID = 1'b0;
        endcase
    end

    // AW and W are latched independently; both flags clear on the commit edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_awHeld <= 1'b0;
            r_wHeld  <= 1'b0;
            r_awIdx  <= '0;
            r_wData  <= '0;
            r_wStrb  <= '0;
        end else if (w_commit) begin
            r_awHeld <= 1'b0;
            r_wHeld  <= 1'b0;
        end else begin
            if (w_awHs) begin
                r_awHeld <= 1'b1;
                r_awIdx  <= S_AXI_AWADDR[4:2];
            end
            if (w_wHs) begin
                r_wHeld <= 1'b1;
                r_wData <= S_AXI_WDATA;
                r_wStrb <= S_AXI_WSTRB;
            end
        end
    end

    assign w_wrOffset   = {r_awIdx, 2'b00};
    assign w_wrOk       = (w_wrOffset == ADDR_GPIO_OUT) || (w_wrOffset == ADDR_SCRATCH);
    assign w_wrMask     = strbToMask(r_wStrb);
    assign w_gpioMerged = (32'(r_gpioOut) & ~w_wrMask) | (r_wData & w_wrMask);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_gpioOut <= GPIO_RST;
            r_scratch <= '0;
            r_bResp   <= RESP_OKAY;
        end else if (w_commit) begin
            r_bResp <= w_wrOk ? RESP_OKAY : RESP_SLVERR;
            if (w_wrOffset == ADDR_GPIO_OUT) begin
                r_gpioOut <= w_gpioMerged[GPIO_W-1:0];
            end
            if (w_wrOffset == ADDR_SCRATCH) begin
                r_scratch <= (r_scratch & ~w_wrMask) | (r_wData & w_wrMask);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rState <= R_IDLE;
        end else begin
            r_rState <= w_rStateNext;
        end
    end

    always_comb begin
        w_rStateNext = r_rState;
        case (r_rState)
            R_IDLE:  if (S_AXI_ARVALID) w_rStateNext = R_DATA;
            R_DATA:  if (S_AXI_RREADY) w_rStateNext = R_IDLE;
            default: w_rStateNext = R_IDLE;
        endcase
    end

    always_comb begin
        S_AXI_ARREADY = (r_rState == R_IDLE);
        S_AXI_RVALID  = (r_rState == R_DATA);
    end

    // Reads sample current register values, so a same-edge write is not yet visible.
    assign w_rdOffset = {S_AXI_ARADDR[4:2], 2'b00};

    always_comb begin
        w_rdData = '0;
        w_rdOk   = 1'b1;
        case (w_rdOffset)
            ADDR_GPIO_OUT: w_rdData = 32'(r_gpioOut);
            ADDR_GPIO_IN:  w_rdData = 32'(w_gpioIn);
            ADDR_SCRATCH:  w_rdData = r_scratch;
            ADDR_ID:       w_rdData = ID_VALUE;
            default:       w_rdOk   = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rData <= '0;
            r_rResp <= RESP_OKAY;
        end else if (w_arHs) begin
            r_rData <= w_rdData;
            r_rResp <= w_rdOk ? RESP_OKAY : RESP_SLVERR;
        end
    end

    assign S_AXI_BRESP = r_bResp;
    assign S_AXI_RDATA = r_rData;
    assign S_AXI_RRESP = r_rResp;
    assign gpio_out    = r_gpioOut;

    assign w_unused = &{1'b0, S_AXI_AWADDR[31:5], S_AXI_AWADDR[1:0],
                        S_AXI_ARADDR[31:5], S_AXI_ARADDR[1:0], w_gpioMerged};

endmodule
